// File: rtl/fac_seq_if.sv
// ---------------------------------------------------------------------------
// fac_seq_if
//
// Handshake between the factorial sequencer and the shared multi-cycle
// multiplier.
//
//   mul_start  sequencer -> multiplier  one-cycle multiply request
//   mul_a      sequencer -> multiplier  128-bit multiplicand (running product)
//   mul_b      sequencer -> multiplier  64-bit multiplier (current count)
//   mul_done   multiplier -> sequencer  one-cycle product-valid pulse
//   mul_p      multiplier -> sequencer  192-bit full product, valid with mul_done
//
// The master modport is the side that issues requests (the sequencer).
// The slave modport is the multiplier.
// ---------------------------------------------------------------------------
interface fac_seq_if;
  logic         mul_start;
  logic [127:0] mul_a;
  logic [63:0]  mul_b;
  logic         mul_done;
  logic [191:0] mul_p;

  modport master (
    output mul_start,
    output mul_a,
    output mul_b,
    input  mul_done,
    input  mul_p
  );

  modport slave (
    input  mul_start,
    input  mul_a,
    input  mul_b,
    output mul_done,
    output mul_p
  );
endinterface

// File: rtl/fac_seq.sv
// ---------------------------------------------------------------------------
// fac_seq
//
// Factorial sequencer. On an accepted start it captures N from operand and
// computes N! by repeated multiplication on an external multi-cycle
// multiplier, running result*cnt, result*(cnt-1), ... down to *2.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   opstart   start request (level or pulse), accepted in IDLE or DONE
//   opclear   clear request, overrides everything else
//   operand   64-bit N, captured on an accepted start
//   int_en    interrupt enable
//   mul       multiplier handshake (master side)
//   result    running / final 128-bit product
//   ovf       sticky overflow: some product needed more than 128 bits
//   opdone    high while the sequencer sits in DONE
//   busy      high while a multiply iteration is in progress
//   op_int    opdone & int_en, registered
//
// Every output comes straight from a flop; nothing combinational reaches
// an output from an input.
// ---------------------------------------------------------------------------
module fac_seq (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          opstart,
  input  logic          opclear,
  input  logic [63:0]   operand,
  input  logic          int_en,
  fac_seq_if.master     mul,
  output logic [127:0]  result,
  output logic          ovf,
  output logic          opdone,
  output logic          busy,
  output logic          op_int
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_REQ  = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t         state_reg;
  logic [63:0]    cnt_reg;
  logic [127:0]   result_reg;
  logic           ovf_reg;
  logic           opdone_reg;
  logic           busy_reg;
  logic           op_int_reg;
  logic           mul_start_reg;
  logic [127:0]   mul_a_reg;
  logic [63:0]    mul_b_reg;

  // Count after the multiply that is completing now; also the operand of
  // the next iteration.
  logic [63:0]    cnt_dec;
  // Upper product bits: any one set means the true product left 128 bits.
  logic           prod_high;

  assign cnt_dec   = cnt_reg - 64'd1;
  assign prod_high = |mul.mul_p[191:128];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 64'd0;
      result_reg    <= 128'd0;
      ovf_reg       <= 1'b0;
      opdone_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      op_int_reg    <= 1'b0;
      mul_start_reg <= 1'b0;
      mul_a_reg     <= 128'd0;
      mul_b_reg     <= 64'd0;
    end else begin
      // The request is a single-cycle pulse; only the transitions into
      // MUL_REQ below raise it again.
      mul_start_reg <= 1'b0;
      // Interrupt follows the registered done flag one cycle later.
      op_int_reg    <= opdone_reg & int_en;

      if (opclear) begin
        // Abandon whatever is in flight. A late mul_done is harmless
        // because only MUL_WAIT looks at it.
        state_reg  <= ST_IDLE;
        cnt_reg    <= 64'd0;
        result_reg <= 128'd0;
        ovf_reg    <= 1'b0;
        opdone_reg <= 1'b0;
        busy_reg   <= 1'b0;
        mul_a_reg  <= 128'd0;
        mul_b_reg  <= 64'd0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (opstart) begin
              cnt_reg    <= operand;
              result_reg <= 128'd1;
              ovf_reg    <= 1'b0;
              if (operand <= 64'd1) begin
                // 0! = 1! = 1: nothing to multiply.
                state_reg  <= ST_DONE;
                opdone_reg <= 1'b1;
                busy_reg   <= 1'b0;
              end else begin
                // First iteration multiplies the seed 1 by N.
                state_reg     <= ST_MUL_REQ;
                opdone_reg    <= 1'b0;
                busy_reg      <= 1'b1;
                mul_start_reg <= 1'b1;
                mul_a_reg     <= 128'd1;
                mul_b_reg     <= operand;
              end
            end
          end

          ST_MUL_REQ: begin
            // mul_a/mul_b were loaded on entry and stay put until the
            // product comes back.
            state_reg <= ST_MUL_WAIT;
          end

          ST_MUL_WAIT: begin
            if (mul.mul_done) begin
              result_reg <= mul.mul_p[127:0];
              ovf_reg    <= ovf_reg | prod_high;
              cnt_reg    <= cnt_dec;
              if (cnt_dec == 64'd1) begin
                // Multiplying by 1 would change nothing, so stop here.
                state_reg  <= ST_DONE;
                opdone_reg <= 1'b1;
                busy_reg   <= 1'b0;
              end else begin
                state_reg     <= ST_MUL_REQ;
                mul_start_reg <= 1'b1;
                mul_a_reg     <= mul.mul_p[127:0];
                mul_b_reg     <= cnt_dec;
              end
            end
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mul.mul_start = mul_start_reg;
  assign mul.mul_a     = mul_a_reg;
  assign mul.mul_b     = mul_b_reg;

  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign opdone = opdone_reg;
  assign busy   = busy_reg;
  assign op_int = op_int_reg;

endmodule
